qspi_psram_responder: RTL and testbench

Synthesizable QSPI PSRAM responder: the device end of the SoC's PSRAM chip-select/clock/quad-IO interface. It decodes serial and quad command frames from the SoC's memory controller. It turns quad reads and writes into byte requests on a simple local memory port, which is backed by on-chip SRAM or a bridge. It lets the PSRAM model be replaced by RTL in FPGA bring-up and gate-level benches.

---
 rtl/qspi_resp_pkg.sv | 29 ++
 rtl/spi_pin_sync.sv | 47 ++++
 rtl/qspi_psram_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_qspi_psram_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_resp_pkg.sv
// Shared definitions for the QSPI PSRAM responder.
// Holds the opcode values, the frame state encoding and the width and
// terminal values of the bit/nibble counter used by the responder FSM.
package qspi_resp_pkg;

  localparam logic [7:0] OP_QREAD     = 8'hEB;
  localparam logic [7:0] OP_QWRITE    = 8'h38;
  localparam logic [7:0] OP_QPI_ENTER = 8'h35;
  localparam logic [7:0] OP_QPI_EXIT  = 8'hF5;
  localparam logic [7:0] OP_RST_EN    = 8'h66;
  localparam logic [7:0] OP_RST       = 8'h99;

  localparam int CNT_W = 8;
  // Terminal counts: index of the last bit/nibble of each field.
  localparam logic [CNT_W-1:0] CMD_SER_LAST = 8'd7;
  localparam logic [CNT_W-1:0] CMD_QPI_LAST = 8'd1;
  localparam logic [CNT_W-1:0] ADDR_LAST    = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronizer for the SPI initiator signals.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   ce_n_i, sck_i, dio_i   raw pins (asynchronous to clk)
//   ce_n_o, dio_o  2-FF synchronized chip select and data lines
//   sck_rise_o, sck_fall_o one-cycle pulses on synchronized sck edges
//   ce_rise_o      one-cycle pulse on synchronized chip-select deassertion
module spi_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_n_i,
  input  logic       sck_i,
  input  logic [3:0] dio_i,
  output logic       ce_n_o,
  output logic [3:0] dio_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       ce_rise_o
);

  // Bit 0/1 form the synchronizer, bit 2 is the delayed copy for edge detect.
  logic [2:0] ce_q;
  logic [2:0] sck_q;
  logic [3:0] dio1_q;
  logic [3:0] dio2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q   <= 3'b111;
      sck_q  <= 3'b000;
      dio1_q <= 4'h0;
      dio2_q <= 4'h0;
    end else begin
      ce_q   <= {ce_q[1:0], ce_n_i};
      sck_q  <= {sck_q[1:0], sck_i};
      dio1_q <= dio_i;
      dio2_q <= dio1_q;
    end
  end

  assign ce_n_o     = ce_q[1];
  assign dio_o      = dio2_q;
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign ce_rise_o  = ce_q[1] & ~ce_q[2];

endmodule

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM responder: device end of a PSRAM chip-select/sck/quad-IO link.
// Decodes serial (or QPI) command frames and turns quad reads/writes into
// byte requests on a simple local memory port.
// Build option: define QSPI_RESP_QPI_EN to honour enter/exit-QPI opcodes;
// otherwise qpi_mode stays 0 and commands are always serial on io0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   spi_ce_n, spi_sck, spi_dio_in initiator pins (synchronized internally)
//   spi_dio_out, spi_dio_oe       io3..io0 drive value and per-line enable
//   mem_addr, mem_wdata           byte address / write byte
//   mem_we, mem_re                requests, held until mem_ready
//   mem_rdata, mem_ready          read byte and one-cycle acknowledge
//   qpi_mode                      commands arrive on 4 lines when set
//   rd_underrun                   pulse: read byte needed before prefetch done
module qspi_psram_responder
  import qspi_resp_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DUMMY  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ce_n,
  input  logic              spi_sck,
  input  logic [3:0]        spi_dio_in,
  output logic [3:0]        spi_dio_out,
  output logic [3:0]        spi_dio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              qpi_mode,
  output logic              rd_underrun
);

`ifdef QSPI_RESP_QPI_EN
  localparam bit QPI_EN = 1'b1;
`else
  localparam bit QPI_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY - 1);

  logic       ce_n_s, sck_rise, sck_fall, ce_rise;
  logic [3:0] dio_s;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ce_n_i    (spi_ce_n),
    .sck_i     (spi_sck),
    .dio_i     (spi_dio_in),
    .ce_n_o    (ce_n_s),
    .dio_o     (dio_s),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .ce_rise_o (ce_rise)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       shreg_q, shreg_d;
  logic              is_rd_q, is_rd_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d, re_q, re_d;
  logic [7:0]        rbuf_q, rbuf_d, obyte_q, obyte_d;
  logic              rbuf_vld_q, rbuf_vld_d;
  logic [3:0]        dout_q, dout_d, oe_q, oe_d;
  logic              qpi_q, qpi_d, under_q, under_d;
  logic [7:0]        cmd_byte;
  logic              cmd_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      is_rd_q    <= 1'b0;
      load_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rbuf_q     <= '0;
      rbuf_vld_q <= 1'b0;
      obyte_q    <= '0;
      dout_q     <= '0;
      oe_q       <= '0;
      qpi_q      <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      is_rd_q    <= is_rd_d;
      load_q     <= load_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rbuf_q     <= rbuf_d;
      rbuf_vld_q <= rbuf_vld_d;
      obyte_q    <= obyte_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      qpi_q      <= qpi_d;
      under_q    <= under_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    is_rd_d    = is_rd_q;
    load_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    re_d       = re_q;
    rbuf_d     = rbuf_q;
    rbuf_vld_d = rbuf_vld_q;
    obyte_d    = obyte_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    qpi_d      = qpi_q;
    under_d    = 1'b0;
    cmd_byte   = qpi_q ? {shreg_q[3:0], dio_s} : {shreg_q[6:0], dio_s[0]};
    cmd_last   = qpi_q ? (cnt_q == CMD_QPI_LAST) : (cnt_q == CMD_SER_LAST);

    // Memory handshakes finish independently of the frame, even after ce_n rises.
    if (re_q && mem_ready) begin
      re_d       = 1'b0;
      rbuf_d     = mem_rdata;
      rbuf_vld_d = 1'b1;
    end
    if (we_q && mem_ready) begin
      we_d   = 1'b0;
      addr_d = addr_q + ADDR_W'(1);
    end
    // Cycle after the last address nibble: latch the address, start the prefetch.
    if (load_q) begin
      addr_d = shreg_q[ADDR_W-1:0];
      if (is_rd_q) begin
        re_d       = 1'b1;
        rbuf_vld_d = 1'b0;
      end
    end

    if (ce_rise) begin
      state_d = ST_IDLE;
      oe_d    = 4'h0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ce_n_s) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            shreg_d = qpi_q ? {shreg_q[19:0], dio_s} : {shreg_q[22:0], dio_s[0]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cmd_last) begin
              cnt_d   = '0;
              state_d = ST_IGNORE;
              case (cmd_byte)
                OP_QREAD:  begin state_d = ST_ADDR; is_rd_d = 1'b1; end
                OP_QWRITE: begin state_d = ST_ADDR; is_rd_d = 1'b0; end
                OP_QPI_ENTER: if (QPI_EN) qpi_d = 1'b1;
                OP_QPI_EXIT:  if (QPI_EN) qpi_d = 1'b0;
                OP_RST_EN, OP_RST: state_d = ST_IGNORE;
                default:           state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            shreg_d = {shreg_q[19:0], dio_s};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = '0;
              load_d  = 1'b1;
              state_d = is_rd_q ? ST_DUMMY : ST_WDATA;
            end
          end
        end
        ST_DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = '0;
              state_d = ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          // cnt_q[0]==0 marks a byte boundary; it stays there while underrunning.
          if (sck_fall) begin
            oe_d = 4'hF;
            if (!cnt_q[0]) begin
              if (rbuf_vld_q) begin
                obyte_d    = rbuf_q;
                dout_d     = rbuf_q[7:4];
                rbuf_vld_d = 1'b0;
                addr_d     = addr_q + ADDR_W'(1);
                re_d       = 1'b1;
                cnt_d      = CNT_W'(1);
              end else begin
                dout_d  = 4'h0;
                under_d = 1'b1;
              end
            end else begin
              dout_d = obyte_q[3:0];
              cnt_d  = '0;
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise) begin
            shreg_d = {shreg_q[19:0], dio_s};
            cnt_d   = cnt_q[0] ? '0 : CNT_W'(1);
            // A byte completing while the previous write is still pending is dropped.
            if (cnt_q[0] && !we_q) begin
              wdata_d = {shreg_q[3:0], dio_s};
              we_d    = 1'b1;
            end
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign spi_dio_out = dout_q;
  assign spi_dio_oe  = oe_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = we_q;
  assign mem_re      = re_q;
  assign qpi_mode    = qpi_q;
  assign rd_underrun = under_q;

endmodule

// File: tb/tb_qspi_psram_responder.sv
module tb_qspi_psram_responder;
  localparam int AW = 24;
  localparam int DM = 6;
`ifdef QSPI_RESP_QPI_EN
  localparam bit QPI_ON = 1'b1;
`else
  localparam bit QPI_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_ce_n = 1'b1;
  logic          spi_sck = 1'b0;
  logic [3:0]    spi_dio_in = 4'h0;
  logic [3:0]    spi_dio_out, spi_dio_oe;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we, mem_re;
  logic [7:0]    mem_rdata = 8'h00;
  logic          mem_ready = 1'b0;
  logic          qpi_mode, rd_underrun;

  qspi_psram_responder #(.ADDR_W(AW), .DUMMY(DM)) dut (
    .clk(clk), .rst(rst), .spi_ce_n(spi_ce_n), .spi_sck(spi_sck),
    .spi_dio_in(spi_dio_in), .spi_dio_out(spi_dio_out), .spi_dio_oe(spi_dio_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .qpi_mode(qpi_mode),
    .rd_underrun(rd_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- memory side: backing store + responder ----------------
  logic [7:0]  mem_store [int];
  logic [7:0]  model_mem [int];
  logic [31:0] wr_log[$];
  logic [23:0] rd_log[$];
  int lat = 2;
  int lcnt = 0;

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] store_get(input logic [23:0] a);
    if (mem_store.exists(int'(a))) return mem_store[int'(a)];
    return dflt(a);
  endfunction
  function automatic logic [7:0] model_get(input logic [23:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return dflt(a);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      lcnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      lcnt = 0;
    end else if (mem_we || mem_re) begin
      lcnt++;
      if (lcnt >= lat) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_store[int'(mem_addr)] = mem_wdata;
          wr_log.push_back({mem_addr, mem_wdata});
        end else begin
          mem_rdata = store_get(mem_addr);
          rd_log.push_back(mem_addr);
        end
      end
    end else begin
      lcnt = 0;
    end
  end

  int und_cnt = 0;
  always @(negedge clk) if (rd_underrun === 1'b1) und_cnt++;

  // ---------------- behavioural model state ----------------
  logic       model_qpi = 1'b0;
  logic [3:0] exp_nib[$];
  logic [31:0] exp_wr[$];
  logic [3:0] obs[$];
  int         und_snap = 0;
  int         phase = 0;   // 0 none, 1 oe must be 0, 2 compare read data, 3 collect
  logic [7:0] wbuf [8];

  // Compare process: initiator samples io on every sck rise.
  always @(posedge spi_sck) begin
    if (spi_ce_n == 1'b0) begin
      if (phase == 1) begin
        check("oe_idle", {28'h0, spi_dio_oe}, 32'h0);
      end else if (phase == 2) begin
        if (exp_nib.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_extra_nibble: got %0h expected none", spi_dio_out);
        end else begin
          logic [3:0] e;
          e = exp_nib.pop_front();
          check("rd_oe", {28'h0, spi_dio_oe}, 32'hF);
          check("rd_nib", {28'h0, spi_dio_out}, {28'h0, e});
        end
      end else if (phase == 3) begin
        obs.push_back(spi_dio_out);
        und_snap = und_cnt;
      end
    end
  end

  // ---------------- initiator tasks ----------------
  task automatic sck_cycle(input logic [3:0] d);
    spi_dio_in = d;
    repeat (5) @(negedge clk);
    spi_sck = 1'b1;
    repeat (5) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic frame_begin();
    spi_ce_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (5) @(negedge clk);
    spi_ce_n = 1'b1;
    spi_dio_in = 4'h0;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    if (model_qpi) begin
      sck_cycle(op[7:4]);
      sck_cycle(op[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]});
    end
    if (QPI_ON && op == 8'h35) model_qpi = 1'b1;
    if (QPI_ON && op == 8'hF5) model_qpi = 1'b0;
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4]);
  endtask

  task automatic preload(input logic [23:0] a, input logic [7:0] d);
    mem_store[int'(a)] = d;
    model_mem[int'(a)] = d;
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    wr_log.delete();
    exp_wr.delete();
    frame_begin();
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      logic [23:0] ai;
      ai = 24'(a + 24'(i));
      sck_cycle(wbuf[i][7:4]);
      sck_cycle(wbuf[i][3:0]);
      exp_wr.push_back({ai, wbuf[i]});
      model_mem[int'(ai)] = wbuf[i];
    end
    frame_end();
    repeat (10) @(negedge clk);
    check("wr_count", wr_log.size(), exp_wr.size());
    while (exp_wr.size() > 0 && wr_log.size() > 0)
      check("wr_event", wr_log.pop_front(), exp_wr.pop_front());
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    rd_log.delete();
    exp_nib.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = model_get(24'(a + 24'(i)));
      exp_nib.push_back(b[7:4]);
      exp_nib.push_back(b[3:0]);
    end
    frame_begin();
    phase = 1;
    send_cmd(8'hEB);
    send_addr(a);
    repeat (DM) sck_cycle(4'h0);
    phase = 2;
    repeat (2 * n) sck_cycle(4'h0);
    phase = 0;
    check("rd_nibbles_left", exp_nib.size(), 0);
    frame_end();
    check("oe_after_frame", {28'h0, spi_dio_oe}, 32'h0);
  endtask

  task automatic cmd_only(input logic [7:0] op);
    frame_begin();
    phase = 1;
    send_cmd(op);
    repeat (4) sck_cycle(4'hF);
    phase = 0;
    frame_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dio_out"}, {28'h0, spi_dio_out}, 32'h0);
    check({tag, "_dio_oe"}, {28'h0, spi_dio_oe}, 32'h0);
    check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_mem_re"}, {31'h0, mem_re}, 32'h0);
    check({tag, "_mem_addr"}, {8'h0, mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, {24'h0, mem_wdata}, 32'h0);
    check({tag, "_qpi_mode"}, {31'h0, qpi_mode}, 32'h0);
    check({tag, "_underrun"}, {31'h0, rd_underrun}, 32'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    int und0;
    logic [3:0] nz[$];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Serial write: A,5,3,C at 0x10
    lat = 2;
    wr_log.delete();
    frame_begin();
    send_cmd(8'h38);
    send_addr(24'h000010);
    sck_cycle(4'hA); sck_cycle(4'h5); sck_cycle(4'h3); sck_cycle(4'hC);
    frame_end();
    repeat (10) @(negedge clk);
    check("wr_lit_count", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("wr_lit_0", wr_log[0], 32'h000010A5);
      check("wr_lit_1", wr_log[1], 32'h0000113C);
    end
    model_mem[16] = 8'hA5;
    model_mem[17] = 8'h3C;
    check("model_pin_10", {24'h0, model_get(24'h10)}, 32'hA5);

    // Serial read of the same two bytes
    do_read(24'h000010, 2);
    check("rd_first_addr", {8'h0, rd_log[0]}, 32'h10);

    // Enter QPI, quad read, exit QPI
    cmd_only(8'h35);
    check("qpi_after_35", {31'h0, qpi_mode}, {31'h0, model_qpi});
    do_read(24'h000010, 2);
    cmd_only(8'hF5);
    check("qpi_after_f5", {31'h0, qpi_mode}, 32'h0);

    // Reset-enable / reset / unknown opcodes have no effect
    wr_log.delete();
    rd_log.delete();
    cmd_only(8'h66);
    cmd_only(8'h99);
    cmd_only(8'h12);
    check("ignore_no_wr", wr_log.size(), 0);
    check("ignore_no_rd", rd_log.size(), 0);

    // Address wrap
    preload(24'hFFFFFF, 8'h96);
    preload(24'h000000, 8'h4B);
    do_read(24'hFFFFFF, 2);
    check("wrap_rd_count_ge2", {31'h0, rd_log.size() >= 2}, 32'h1);
    if (rd_log.size() >= 2) begin
      check("wrap_addr0", {8'h0, rd_log[0]}, 32'hFFFFFF);
      check("wrap_addr1", {8'h0, rd_log[1]}, 32'h0);
    end

    // Prefetch underrun
    preload(24'h000040, 8'hA5);
    preload(24'h000041, 8'h3C);
    lat = 200;
    obs.delete();
    und_cnt = 0;
    frame_begin();
    send_cmd(8'hEB);
    send_addr(24'h000040);
    repeat (DM) sck_cycle(4'h0);
    phase = 3;
    repeat (24) sck_cycle(4'h0);
    phase = 0;
    frame_end();
    repeat (300) @(negedge clk);
    lat = 2;
    zeros = 0;
    nz.delete();
    foreach (obs[i]) begin
      if (obs[i] == 4'h0) zeros++;
      else nz.push_back(obs[i]);
    end
    check("under_first_nib", {28'h0, obs[0]}, 32'h0);
    check("under_pulses", und_snap, zeros);
    check("under_nz_count", nz.size(), 2);
    if (nz.size() >= 2) begin
      check("under_nz0", {28'h0, nz[0]}, 32'hA);
      check("under_nz1", {28'h0, nz[1]}, 32'h5);
    end

    // Write aborted after one nibble
    wr_log.delete();
    frame_begin();
    send_cmd(8'h38);
    send_addr(24'h000020);
    sck_cycle(4'h7);
    frame_end();
    repeat (20) @(negedge clk);
    check("abort_no_we", wr_log.size(), 0);

    // Randomized write-then-read-back frames
    und0 = und_cnt;
    for (int it = 0; it < 8; it++) begin
      logic [23:0] a;
      int n;
      lat = $urandom_range(1, 10);
      a = 24'($urandom);
      if (it == 3) a = 24'hFFFFFE;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      do_write(a, n);
      do_read(a, n);
    end
    check("random_no_underrun", und_cnt - und0, 0);

    // Reset asserted mid-read
    lat = 2;
    frame_begin();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    repeat (DM) sck_cycle(4'h0);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    spi_ce_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
